// File: rtl/aes_frame_loader.sv
// Frame assembler ahead of aes_top: collects SYNC + 16 key + 16 plaintext bytes + XOR checksum,
// then launches one AES operation per verified frame and waits for the core to finish.
module aes_frame_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_rx_valid,
  input  logic [7:0]   i_rx_byte,
  input  logic         i_aes_done,
  output logic [0:127] o_key,
  output logic [0:127] o_plain,
  output logic         o_start,
  output logic         o_busy,
  output logic         o_frame_err,
  output logic [7:0]   o_err_count,
  output logic         o_overrun
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, KEY, PLAIN, CHECK, START, WAIT_DONE} state_t;

  state_t         state, state_nxt;
  logic [3:0]     idx;
  logic [7:0]     acc;
  logic [TW-1:0]  tcnt;
  logic [0:127]   key_sh, plain_sh;
  logic           in_frame, timeout, frame_fail, load;

  assign in_frame = (state == KEY) || (state == PLAIN) || (state == CHECK);
  // Expiry fires on the idle cycle that would bring the count to TIMEOUT_CYCLES; a byte that cycle wins.
  assign timeout  = in_frame && !i_rx_valid && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt  = state;
    frame_fail = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE:      if (i_rx_valid && i_rx_byte == SYNC_BYTE) state_nxt = KEY;
      KEY:       if (i_rx_valid && idx == 4'd15) state_nxt = PLAIN;
      PLAIN:     if (i_rx_valid && idx == 4'd15) state_nxt = CHECK;
      CHECK: begin
        if (i_rx_valid) begin
          if (i_rx_byte == acc) begin
            state_nxt = START;
            load      = 1'b1;
          end else begin
            state_nxt  = IDLE;
            frame_fail = 1'b1;
          end
        end
      end
      START:     state_nxt = WAIT_DONE;
      WAIT_DONE: if (i_aes_done) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (timeout) begin
      state_nxt  = IDLE;
      frame_fail = 1'b1;
    end
  end

  assign o_start = (state == START);
  assign o_busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      acc         <= '0;
      tcnt        <= '0;
      key_sh      <= '0;
      plain_sh    <= '0;
      o_key       <= '0;
      o_plain     <= '0;
      o_frame_err <= 1'b0;
      o_err_count <= '0;
      o_overrun   <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_frame_err <= frame_fail;
      if (frame_fail && o_err_count != 8'hFF) o_err_count <= o_err_count + 8'd1;
      if (i_rx_valid && (state == START || state == WAIT_DONE)) o_overrun <= 1'b1;
      if (in_frame) tcnt <= i_rx_valid ? '0 : tcnt + 1'b1;
      // idx wraps 15 -> 0, which also clears it on the KEY -> PLAIN transition.
      case (state)
        IDLE: begin
          if (i_rx_valid && i_rx_byte == SYNC_BYTE) begin
            idx  <= '0;
            acc  <= '0;
            tcnt <= '0;
          end
        end
        KEY: begin
          if (i_rx_valid) begin
            key_sh <= {key_sh[8:127], i_rx_byte};
            acc    <= acc ^ i_rx_byte;
            idx    <= idx + 4'd1;
          end
        end
        PLAIN: begin
          if (i_rx_valid) begin
            plain_sh <= {plain_sh[8:127], i_rx_byte};
            acc      <= acc ^ i_rx_byte;
            idx      <= idx + 4'd1;
          end
        end
        default: ;
      endcase
      if (load) begin
        o_key   <= key_sh;
        o_plain <= plain_sh;
      end
    end
  end

endmodule

// File: tb/tb_aes_frame_loader.sv
// Randomized self-checking bench for aes_frame_loader; expectations come from a frame-level model
// (byte lists, XOR checksum, saturating error tally) kept in the bench.
module tb_aes_frame_loader;

  localparam int unsigned TMO = 50;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_rx_valid;
  logic [7:0]   i_rx_byte;
  logic         i_aes_done;
  logic [0:127] o_key, o_plain;
  logic         o_start, o_busy, o_frame_err, o_overrun;
  logic [7:0]   o_err_count;

  int tests = 0;
  int fails = 0;
  int n_start = 0;
  int n_err = 0;

  logic [127:0] exp_key, exp_plain;
  int           exp_errs;
  logic         exp_overrun;

  aes_frame_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .i_rx_valid(i_rx_valid), .i_rx_byte(i_rx_byte),
    .i_aes_done(i_aes_done), .o_key(o_key), .o_plain(o_plain), .o_start(o_start),
    .o_busy(o_busy), .o_frame_err(o_frame_err), .o_err_count(o_err_count), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_start) n_start <= n_start + 1;
    if (o_frame_err) n_err <= n_err + 1;
  end

  // One clock cycle: drive at a negedge, return at the next negedge (after the active edge).
  task automatic cycle(input logic v, input logic [7:0] b);
    i_rx_valid = v;
    i_rx_byte  = b;
    @(negedge clk);
    i_rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] byte_of(input logic [127:0] blk, input int i);
    return blk[127 - 8*i -: 8];
  endfunction

  function automatic logic [7:0] xsum(input logic [127:0] k, input logic [127:0] p);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < 16; i++) s = s ^ byte_of(k, i) ^ byte_of(p, i);
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic gap(input int max_gap);
    int n = $urandom_range(0, max_gap);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom));
  endtask

  // Sends a whole frame; the checksum is XORed with cs_flip. Returns just after the checksum edge.
  task automatic send_frame(input logic [127:0] k, input logic [127:0] p,
                            input logic [7:0] cs_flip, input int max_gap);
    cycle(1'b1, 8'hA5);
    for (int i = 0; i < 16; i++) begin gap(max_gap); cycle(1'b1, byte_of(k, i)); end
    for (int i = 0; i < 16; i++) begin gap(max_gap); cycle(1'b1, byte_of(p, i)); end
    gap(max_gap);
    cycle(1'b1, xsum(k, p) ^ cs_flip);
  endtask

  task automatic finish_aes();
    i_aes_done = 1'b1;
    @(negedge clk);
    i_aes_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    rst = 1'b0;
    exp_key = '0; exp_plain = '0; exp_errs = 0; exp_overrun = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    tests++;
    if ({o_key, o_plain} !== 256'h0 || o_start !== 1'b0 || o_busy !== 1'b0 || o_frame_err !== 1'b0 ||
        o_overrun !== 1'b0 || o_err_count !== 8'h00) begin
      fails++;
      $display("FAIL reset: key=%h plain=%h start=%b busy=%b err=%b ovr=%b cnt=%0d, required all 0",
               o_key, o_plain, o_start, o_busy, o_frame_err, o_overrun, o_err_count);
    end
    rst = 1'b0;
    exp_key = '0; exp_plain = '0; exp_errs = 0; exp_overrun = 1'b0;
  endtask

  task automatic test_fips();
    logic [127:0] k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    logic [127:0] p = 128'h3243f6a8885a308d313198a2e0370734;
    int s0 = n_start;
    send_frame(k, p, 8'h00, 0);
    exp_key = k; exp_plain = p;
    tests++;
    if (o_start !== 1'b1 || o_busy !== 1'b1) begin
      fails++; $display("FAIL fips_start: start=%b busy=%b, required 1 1", o_start, o_busy);
    end
    tests++;
    if (o_key !== exp_key || o_plain !== exp_plain) begin
      fails++; $display("FAIL fips_data: key=%h plain=%h, required %h %h", o_key, o_plain, exp_key, exp_plain);
    end
    cycle(1'b0, 8'h00);
    tests++;
    if (o_start !== 1'b0 || o_busy !== 1'b1) begin
      fails++; $display("FAIL fips_wait: start=%b busy=%b, required 0 1", o_start, o_busy);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00);
    finish_aes();
    tests++;
    if (o_busy !== 1'b0 || n_start - s0 !== 1) begin
      fails++; $display("FAIL fips_done: busy=%b starts=%0d, required 0 1", o_busy, n_start - s0);
    end
  endtask

  task automatic test_bad_checksum();
    int s0 = n_start;
    do_reset();
    send_frame(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734, 8'h01, 0);
    exp_errs++;
    tests++;
    if (o_frame_err !== 1'b1 || o_busy !== 1'b0 || o_err_count !== 8'(exp_errs)) begin
      fails++; $display("FAIL badcs_err: err=%b busy=%b cnt=%0d, required 1 0 %0d", o_frame_err, o_busy, o_err_count, exp_errs);
    end
    cycle(1'b0, 8'h00);
    tests++;
    if (o_frame_err !== 1'b0 || n_start != s0 || o_key !== exp_key || o_plain !== exp_plain) begin
      fails++; $display("FAIL badcs_out: err=%b starts=%0d key=%h plain=%h, required 0 0 and zero data",
                        o_frame_err, n_start - s0, o_key, o_plain);
    end
  endtask

  task automatic test_junk_sync();
    logic [127:0] k = rand128();
    logic [127:0] p = rand128();
    k[127-8*3 -: 8] = 8'hA5;
    p[127-8*9 -: 8] = 8'hA5;
    cycle(1'b1, 8'h00); cycle(1'b1, 8'hFF); cycle(1'b1, 8'h3C);
    tests++;
    if (o_busy !== 1'b0) begin fails++; $display("FAIL junk_idle: busy=%b, required 0", o_busy); end
    send_frame(k, p, 8'h00, 3);
    exp_key = k; exp_plain = p;
    tests++;
    if (o_start !== 1'b1 || o_key !== exp_key || o_plain !== exp_plain) begin
      fails++; $display("FAIL junk_frame: start=%b key=%h plain=%h, required 1 %h %h", o_start, o_key, o_plain, k, p);
    end
    cycle(1'b0, 8'h00);
    finish_aes();
  endtask

  task automatic test_timeout();
    logic [127:0] k = rand128();
    logic [127:0] p = rand128();
    int e0;
    cycle(1'b1, 8'hA5);
    for (int i = 0; i < 10; i++) cycle(1'b1, byte_of(k, i));
    e0 = n_err;
    for (int i = 0; i < 49; i++) cycle(1'b0, 8'h00);
    tests++;
    if (o_frame_err !== 1'b0 || o_busy !== 1'b1 || n_err != e0) begin
      fails++; $display("FAIL tmo_early: err=%b busy=%b pulses=%0d, required 0 1 0", o_frame_err, o_busy, n_err - e0);
    end
    cycle(1'b0, 8'h00);
    exp_errs++;
    tests++;
    if (o_frame_err !== 1'b1 || o_busy !== 1'b0 || o_err_count !== 8'(exp_errs)) begin
      fails++; $display("FAIL tmo_expire: err=%b busy=%b cnt=%0d, required 1 0 %0d", o_frame_err, o_busy, o_err_count, exp_errs);
    end
    send_frame(k, p, 8'h00, 2);
    exp_key = k; exp_plain = p;
    tests++;
    if (o_start !== 1'b1 || o_key !== exp_key || o_plain !== exp_plain) begin
      fails++; $display("FAIL tmo_recover: start=%b key=%h, required 1 %h", o_start, o_key, k);
    end
    cycle(1'b0, 8'h00);
    finish_aes();
    // Byte arrives on the exact expiry cycle: frame must survive.
    k = rand128(); p = rand128();
    e0 = n_err;
    cycle(1'b1, 8'hA5);
    for (int i = 0; i < 10; i++) cycle(1'b1, byte_of(k, i));
    for (int i = 0; i < 49; i++) cycle(1'b0, 8'h00);
    for (int i = 10; i < 16; i++) cycle(1'b1, byte_of(k, i));
    for (int i = 0; i < 16; i++) cycle(1'b1, byte_of(p, i));
    cycle(1'b1, xsum(k, p));
    exp_key = k; exp_plain = p;
    tests++;
    if (o_start !== 1'b1 || n_err != e0 || o_key !== exp_key || o_plain !== exp_plain) begin
      fails++; $display("FAIL tmo_edge_byte: start=%b pulses=%0d key=%h, required 1 0 %h", o_start, n_err - e0, o_key, k);
    end
    cycle(1'b0, 8'h00);
    finish_aes();
  endtask

  task automatic test_overrun_and_reset();
    logic [127:0] k = rand128();
    logic [127:0] p = rand128();
    int e0;
    send_frame(k, p, 8'h00, 1);
    exp_key = k; exp_plain = p;
    cycle(1'b1, 8'($urandom));
    exp_overrun = 1'b1;
    cycle(1'b1, 8'hA5);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom));
    tests++;
    if (o_overrun !== exp_overrun || o_busy !== 1'b1 || o_key !== exp_key || o_plain !== exp_plain) begin
      fails++; $display("FAIL overrun: ovr=%b busy=%b key=%h, required 1 1 %h", o_overrun, o_busy, o_key, k);
    end
    finish_aes();
    tests++;
    if (o_overrun !== exp_overrun || o_busy !== 1'b0) begin
      fails++; $display("FAIL overrun_sticky: ovr=%b busy=%b, required 1 0", o_overrun, o_busy);
    end
    k = rand128(); p = rand128();
    cycle(1'b1, 8'hA5);
    for (int i = 0; i < 16; i++) cycle(1'b1, byte_of(k, i));
    for (int i = 0; i < 5; i++) cycle(1'b1, byte_of(p, i));
    e0 = n_err;
    rst = 1'b1;
    cycle(1'b0, 8'h00);
    rst = 1'b0;
    exp_key = '0; exp_plain = '0; exp_errs = 0; exp_overrun = 1'b0;
    cycle(1'b0, 8'h00);
    tests++;
    if ({o_key, o_plain} !== 256'h0 || o_busy !== 1'b0 || o_overrun !== 1'b0 || o_err_count !== 8'h00 ||
        n_err != e0 || o_frame_err !== 1'b0) begin
      fails++; $display("FAIL midframe_reset: key=%h busy=%b ovr=%b cnt=%0d pulses=%0d, required all 0",
                        o_key, o_busy, o_overrun, o_err_count, n_err - e0);
    end
  endtask

  task automatic test_saturate();
    for (int f = 0; f < 260; f++) begin
      send_frame(rand128(), rand128(), 8'($urandom_range(1, 255)), 0);
      if (exp_errs < 255) exp_errs++;
      tests++;
      if (o_frame_err !== 1'b1 || o_err_count !== 8'(exp_errs)) begin
        fails++; $display("FAIL saturate[%0d]: err=%b cnt=%0d, required 1 %0d", f, o_frame_err, o_err_count, exp_errs);
      end
    end
    tests++;
    if (o_start !== 1'b0 || o_key !== exp_key) begin
      fails++; $display("FAIL saturate_out: start=%b key=%h, required 0 %h", o_start, o_key, exp_key);
    end
  endtask

  initial begin
    rst = 1'b1; i_rx_valid = 1'b0; i_rx_byte = 8'h00; i_aes_done = 1'b0;
    @(negedge clk);
    test_reset();
    test_fips();
    test_bad_checksum();
    test_junk_sync();
    test_timeout();
    test_overrun_and_reset();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
